data_port: RTL and testbench
============================

DATA_PORT -- requirements
Module: data_port

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 address_enable  input  1  read-stage load request; held high with address stable until data_valid is sampled high.
REQ-004 address  input  regval_t  load address, passed unchanged to backend.
REQ-005 data_valid  output  1  response strobe; high for exactly the cycle data is valid for the current address.
REQ-006 data  output  regval_t  load result, registered.
REQ-007 mem_read  output  1  backend read request, held until accepted.
REQ-008 mem_address  output  regval_t  backend address, equals captured request address.
REQ-009 mem_waitrequest  input  1  backend stall; mem_read accepted on an edge where it is low.
REQ-010 mem_readdatavalid  input  1  backend read data present this cycle.
REQ-011 mem_readdata  input  regval_t  backend read data.
REQ-012 snoop_enable  input  1  store in progress (from write stage).
REQ-013 snoop_address  input  regval_t  store address.

Function
REQ-014 The state machine SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: address_enable high at an edge -> capture address into req_addr, clear stale, go ISSUE.
REQ-016 ISSUE: mem_read=1, mem_address=req_addr; edge with mem_waitrequest low -> WAIT.
REQ-017 WAIT: edge with mem_readdatavalid high -> register mem_readdata into data; go DONE if not stale, else IDLE.
REQ-018 DONE: data_valid = address_enable && (address == req_addr); next edge -> IDLE unconditionally.
REQ-019 data_valid SHALL be 0 in every state except DONE.
REQ-020 Minimum miss latency (zero backend wait, readdatavalid in the cycle after acceptance): request sampled at edge N, data_valid high between edges N+3 and N+4.
REQ-021 Abort: in ISSUE or WAIT, any edge with address_enable low or address != req_addr SHALL set stale; mem_read SHALL NOT be withdrawn before acceptance; the stale result SHALL be discarded without a data_valid pulse.
REQ-022 After an aborted request returns to IDLE, a pending new request SHALL be captured at the next edge.
REQ-023 mem_readdatavalid outside WAIT SHALL be ignored.
REQ-024 Back-to-back requests: after DONE, a new request SHALL be captured no earlier than the IDLE edge that follows.

Reset
REQ-025 reset high at an edge -> state IDLE, stale 0, data 0, req_addr 0; mem_read and data_valid 0 in the following cycle.
REQ-026 Reset mid-ISSUE/WAIT SHALL drop the request; a later mem_readdatavalid SHALL be ignored.
REQ-027 Reset SHALL take priority over all other events on the same edge.

Configuration
REQ-028 Macro DATA_PORT_CACHE_EN SHALL enable a one-entry response cache (tag, value, valid).
REQ-029 With DATA_PORT_CACHE_EN: IDLE request with valid tag==address and snoop not matching this cycle -> go DONE with data=cached value; data_valid in the cycle after capture, no backend access.
REQ-030 With DATA_PORT_CACHE_EN: each non-stale WAIT completion fills the entry; snoop_enable with snoop_address==tag clears valid; a snoop matching req_addr during ISSUE/WAIT prevents the fill but still returns the data; when a snoop invalidate and a fill coincide, invalidate wins; reset clears valid.
REQ-031 Without DATA_PORT_CACHE_EN: no cache storage; snoop inputs SHALL be ignored; behaviour exactly as REQ-014..027.

Structure
REQ-032 regval_t and the enum data_port_state_t SHALL live in the shared types package.
REQ-033 The cache SHALL be a sub-module data_port_cache, instantiated only under DATA_PORT_CACHE_EN.

Verification
REQ-034 Reset mid-WAIT, then mem_readdatavalid with 0xDEADBEEF -> no data_valid; state IDLE; mem_read 0.
REQ-035 Request 0x100, waitrequest 0, readdata 0x12345678 one cycle after acceptance -> data_valid for one cycle 3 cycles after capture, data=0x12345678.
REQ-036 Request 0x200, waitrequest high 4 cycles -> mem_read held 5 cycles at 0x200, then normal response.
REQ-037 Request 0x300, address changes to 0x304 during WAIT -> 0x300 data discarded, new mem_read at 0x304, data_valid only for 0x304.
REQ-038 Cache enabled: load 0x400 (miss), load 0x400 again -> second data_valid 1 cycle after capture, no mem_read; snoop 0x400 then load -> miss via backend.
REQ-039 Cache enabled: snoop 0x500 during WAIT of load 0x500 -> data returned, subsequent 0x500 load misses.

Source files
------------

// File: rtl/data_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_port_pkg
// Description : Shared types for the data_port load unit: register-width
//               value type and the load state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_port_pkg;

    localparam int c_regval_width = 32;

    typedef logic [c_regval_width-1:0] regval_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } data_port_state_t;

endpackage
`default_nettype wire

// File: rtl/data_port_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_port_cache
// Description : One-entry load response cache (tag, value, valid). Stores
//               invalidate the entry by address; a store to the address being
//               filled suppresses the fill.
// Revision    : 1.0 - initial release
// ============================================================================
module data_port_cache
    import data_port_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  regval_t lookup_address,
    input  logic    snoop_enable,
    input  regval_t snoop_address,
    input  logic    fill_enable,
    input  regval_t fill_address,
    input  regval_t fill_data,
    output logic    hit,
    output regval_t hit_data
);

    logic    r_valid;
    regval_t r_tag;
    regval_t r_value;
    logic    w_snoop_tag;
    logic    w_snoop_fill;
    logic    w_snoop_lookup;
    logic    w_do_fill;

    assign w_snoop_tag    = snoop_enable && (snoop_address == r_tag);
    assign w_snoop_fill   = snoop_enable && (snoop_address == fill_address);
    assign w_snoop_lookup = snoop_enable && (snoop_address == lookup_address);
    assign w_do_fill      = fill_enable && !w_snoop_fill;

    // Entry update: an invalidate always beats a fill landing on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_value <= '0;
        end else begin
            if (w_do_fill) begin
                r_tag   <= fill_address;
                r_value <= fill_data;
            end
            if (w_snoop_tag) begin
                r_valid <= 1'b0;
            end else if (w_do_fill) begin
                r_valid <= 1'b1;
            end
        end
    end

    // A store to the looked-up address in the same cycle forces a miss
    assign hit      = r_valid && (r_tag == lookup_address) && !w_snoop_lookup;
    assign hit_data = r_value;

endmodule
`default_nettype wire

// File: rtl/data_port.sv
`default_nettype none
// ============================================================================
// Module      : data_port
// Description : Read-stage load port. Captures a load address, issues one
//               backend read, and returns a single data_valid strobe while the
//               requester still presents the same address. Requests abandoned
//               mid-flight are completed on the backend and discarded.
//               Optional response cache enabled by `define DATA_PORT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_port
    import data_port_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    address_enable,
    input  regval_t address,
    output logic    data_valid,
    output regval_t data,
    output logic    mem_read,
    output regval_t mem_address,
    input  logic    mem_waitrequest,
    input  logic    mem_readdatavalid,
    input  regval_t mem_readdata,
    input  logic    snoop_enable,
    input  regval_t snoop_address
);

    data_port_state_t r_state;
    data_port_state_t w_next_state;
    regval_t          r_req_addr;
    regval_t          r_data;
    logic             r_stale;
    logic             w_capture;
    logic             w_in_flight;
    logic             w_abort;
    logic             w_complete;
    logic             w_stale_now;
    logic             w_hit;
    regval_t          w_hit_data;

    assign w_capture   = (r_state == IDLE) && address_enable;
    assign w_in_flight = (r_state == ISSUE) || (r_state == WAIT);
    assign w_abort     = w_in_flight && (!address_enable || (address != r_req_addr));
    assign w_complete  = (r_state == WAIT) && mem_readdatavalid;
    // An abort seen on the completion edge itself must also discard the data
    assign w_stale_now = r_stale || w_abort;

`ifdef DATA_PORT_CACHE_EN
    logic    r_snooped;
    logic    w_snoop_req;
    logic    w_fill;
    logic    w_cache_hit;

    assign w_snoop_req = snoop_enable &&
                         (snoop_address == (w_capture ? address : r_req_addr));
    assign w_fill      = w_complete && !w_stale_now && !r_snooped;
    assign w_hit       = w_cache_hit;

    // Remember whether a store hit the outstanding request so its data is not cached
    always_ff @(posedge clock) begin
        if (reset) begin
            r_snooped <= 1'b0;
        end else if (w_capture) begin
            r_snooped <= w_snoop_req;
        end else if (w_in_flight && w_snoop_req) begin
            r_snooped <= 1'b1;
        end
    end

    data_port_cache u_cache (
        .clock          (clock),
        .reset          (reset),
        .lookup_address (address),
        .snoop_enable   (snoop_enable),
        .snoop_address  (snoop_address),
        .fill_enable    (w_fill),
        .fill_address   (r_req_addr),
        .fill_data      (mem_readdata),
        .hit            (w_cache_hit),
        .hit_data       (w_hit_data)
    );
`else
    logic w_unused_snoop;

    assign w_hit          = 1'b0;
    assign w_hit_data     = '0;
    assign w_unused_snoop = snoop_enable ^ (^snoop_address);
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (address_enable)    w_next_state = w_hit ? DONE : ISSUE;
            ISSUE:   if (!mem_waitrequest)  w_next_state = WAIT;
            WAIT:    if (mem_readdatavalid) w_next_state = w_stale_now ? IDLE : DONE;
            DONE:                           w_next_state = IDLE;
            default:                        w_next_state = IDLE;
        endcase
    end

    // Request address, abort flag and registered load result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_addr <= '0;
            r_stale    <= 1'b0;
            r_data     <= '0;
        end else begin
            if (w_capture) begin
                r_req_addr <= address;
                r_stale    <= 1'b0;
                if (w_hit) begin
                    r_data <= w_hit_data;
                end
            end else if (w_abort) begin
                r_stale <= 1'b1;
            end
            if (w_complete) begin
                r_data <= mem_readdata;
            end
        end
    end

    // Outputs: backend request in ISSUE, response strobe only while the address still matches
    always_comb begin
        mem_read    = (r_state == ISSUE);
        mem_address = r_req_addr;
        data_valid  = (r_state == DONE) && address_enable && (address == r_req_addr);
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_data_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_port
// Description : Self-checking bench for data_port. Transaction-level model:
//               expected strobe cycle is computed from capture edge, backend
//               wait count and response gap; cache modelled as tag/value/valid.
//               Cache expectations follow `define DATA_PORT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_port;
    import data_port_pkg::*;

`ifdef DATA_PORT_CACHE_EN
    localparam bit C_CACHE_EN = 1'b1;
`else
    localparam bit C_CACHE_EN = 1'b0;
`endif

    logic    clock;
    logic    reset;
    logic    address_enable;
    regval_t address;
    logic    data_valid;
    regval_t data;
    logic    mem_read;
    regval_t mem_address;
    logic    mem_waitrequest;
    logic    mem_readdatavalid;
    regval_t mem_readdata;
    logic    snoop_enable;
    regval_t snoop_address;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference cache model
    bit      m_valid = 1'b0;
    regval_t m_tag   = '0;
    regval_t m_value = '0;

    data_port dut (
        .clock             (clock),
        .reset             (reset),
        .address_enable    (address_enable),
        .address           (address),
        .data_valid        (data_valid),
        .data              (data),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .snoop_enable      (snoop_enable),
        .snoop_address     (snoop_address)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One load held until its strobe; snoop_k >= 0 injects a store to addr k cycles after capture
    task automatic do_load(input regval_t addr, input int waits, input int gap,
                           input regval_t rdata, input int snoop_k);
        bit      hit;
        bit      snooped;
        int      cap, acc, rdv, dv;
        regval_t exp_data;
        hit     = C_CACHE_EN && m_valid && (m_tag == addr);
        snooped = 1'b0;
        address_enable = 1'b1;
        address        = addr;
        tick();
        cap = cyc;
        if (hit) begin
            acc = cap; rdv = cap; dv = cap; exp_data = m_value;
        end else begin
            acc = cap + 1 + waits; rdv = acc + 1 + gap; dv = rdv; exp_data = rdata;
        end
        for (int c = cap; c <= dv; c++) begin
            mem_waitrequest = (c != acc - 1);
            if (!hit && c == rdv - 1) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = rdata;
            end else if (c < acc || c == dv) begin
                mem_readdatavalid = 1'($urandom_range(0, 1));
                mem_readdata      = $urandom;
            end else begin
                mem_readdatavalid = 1'b0;
                mem_readdata      = $urandom;
            end
            snoop_enable  = !hit && (snoop_k >= 0) && (c == cap + snoop_k);
            snoop_address = addr;
            if (snoop_enable) snooped = 1'b1;
            @(negedge clock);
            chk("mem_read", mem_read, !hit && c < acc);
            if (!hit && c < acc) chk("mem_address", mem_address, addr);
            chk("data_valid", data_valid, c == dv);
            if (c == dv) chk("data", data, exp_data);
            tick();
        end
        address_enable    = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b1;
        snoop_enable      = 1'b0;
        if (C_CACHE_EN && !hit) begin
            if (snooped) begin
                if (m_tag == addr) m_valid = 1'b0;
            end else begin
                m_valid = 1'b1; m_tag = addr; m_value = rdata;
            end
        end
        @(negedge clock);
        chk("idle_data_valid", data_valid, 1'b0);
        chk("idle_mem_read", mem_read, 1'b0);
        chk("data_hold", data, exp_data);
        tick();
    endtask

    // Load abandoned k cycles after capture (drop enable or switch to b); ends in IDLE
    task automatic do_abort(input regval_t a, input regval_t b, input bit drop,
                            input int waits, input int gap, input int k);
        int cap, acc, rdv;
        address_enable = 1'b1;
        address        = a;
        tick();
        cap = cyc;
        acc = cap + 1 + waits;
        rdv = acc + 1 + gap;
        for (int c = cap; c < rdv; c++) begin
            if (c == cap + k) begin
                if (drop) address_enable = 1'b0;
                else      address = b;
            end
            mem_waitrequest   = (c != acc - 1);
            mem_readdatavalid = (c == rdv - 1);
            mem_readdata      = $urandom;
            @(negedge clock);
            chk("abort_mem_read", mem_read, c < acc);
            if (c < acc) chk("abort_mem_address", mem_address, a);
            chk("abort_data_valid", data_valid, 1'b0);
            tick();
        end
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b1;
        @(negedge clock);
        chk("abort_idle_data_valid", data_valid, 1'b0);
        chk("abort_idle_mem_read", mem_read, 1'b0);
    endtask

    // Idle cycle with a store snoop
    task automatic do_snoop(input regval_t a);
        snoop_enable  = 1'b1;
        snoop_address = a;
        @(negedge clock);
        chk("snoop_data_valid", data_valid, 1'b0);
        chk("snoop_mem_read", mem_read, 1'b0);
        tick();
        snoop_enable = 1'b0;
        if (C_CACHE_EN && m_tag == a) m_valid = 1'b0;
    endtask

    // Reset while waiting for read data; the late response must be ignored
    task automatic do_reset_mid(input regval_t addr, input int waits);
        address_enable  = 1'b1;
        address         = addr;
        mem_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            chk("rst_issue_mem_read", mem_read, 1'b1);
            tick();
        end
        mem_waitrequest = 1'b0;
        @(negedge clock);
        chk("rst_issue_mem_read", mem_read, 1'b1);
        tick();
        mem_waitrequest   = 1'b1;
        reset             = 1'b1;
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'hDEADBEEF;
        @(negedge clock);
        chk("rst_wait_data_valid", data_valid, 1'b0);
        tick();
        reset          = 1'b0;
        address_enable = 1'b0;
        m_valid        = 1'b0;
        @(negedge clock);
        chk("rst_after_mem_read", mem_read, 1'b0);
        chk("rst_after_data_valid", data_valid, 1'b0);
        chk("rst_after_data", data, 32'h0);
        tick();
        mem_readdatavalid = 1'b0;
        @(negedge clock);
        chk("rst_late_mem_read", mem_read, 1'b0);
        chk("rst_late_data_valid", data_valid, 1'b0);
        chk("rst_late_data", data, 32'h0);
        tick();
    endtask

    initial begin
        reset             = 1'b1;
        address_enable    = 1'b0;
        address           = '0;
        mem_waitrequest   = 1'b1;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        snoop_enable      = 1'b0;
        snoop_address     = '0;
        tick();
        tick();
        @(negedge clock);
        chk("reset_data_valid", data_valid, 1'b0);
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_data", data, 32'h0);
        chk("reset_mem_address", mem_address, 32'h0);
        // Reset beats a pending request on the same edge
        address_enable = 1'b1;
        address        = 32'h0000_0880;
        tick();
        reset          = 1'b0;
        address_enable = 1'b0;
        @(negedge clock);
        chk("reset_prio_mem_read", mem_read, 1'b0);
        tick();

        // Minimum-latency miss
        do_load(32'h0000_0100, 0, 1, 32'h1234_5678, -1);
        // Backend stall of four cycles
        do_load(32'h0000_0200, 4, 1, 32'hCAFE_0200, -1);
        // Address moves during WAIT: first result dropped, new request follows
        do_abort(32'h0000_0300, 32'h0000_0304, 1'b0, 1, 2, 2);
        do_load(32'h0000_0304, 0, 1, 32'h0304_0304, -1);
        // Enable dropped while still stalled in ISSUE
        do_abort(32'h0000_0310, 32'h0000_0310, 1'b1, 3, 1, 1);
        do_load(32'h0000_0310, 1, 2, 32'h0310_0310, -1);
        // Repeat load, then store-invalidate and reload
        do_load(32'h0000_0400, 0, 1, 32'h4444_0400, -1);
        do_load(32'h0000_0400, 0, 1, 32'h5555_0400, -1);
        do_snoop(32'h0000_0400);
        do_load(32'h0000_0400, 1, 1, 32'h6666_0400, -1);
        // Store to the outstanding address during WAIT
        do_load(32'h0000_0500, 0, 2, 32'h7777_0500, 2);
        do_load(32'h0000_0500, 0, 1, 32'h8888_0500, -1);
        // Reset mid-WAIT with a late response
        do_reset_mid(32'h0000_0700, 1);
        do_load(32'h0000_0100, 0, 1, 32'h0BAD_F00D, -1);

        for (int n = 0; n < 40; n++) begin
            int      op;
            int      w;
            int      g;
            regval_t a;
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 4);
            g  = $urandom_range(1, 3);
            a  = 32'h0000_1000 + 32'($urandom_range(0, 3) * 4);
            if (op <= 4) begin
                do_load(a, w, g, $urandom, -1);
            end else if (op == 5) begin
                do_load(a, w, g, $urandom, $urandom_range(0, w + g + 1));
            end else if (op <= 7) begin
                if (C_CACHE_EN && m_valid && m_tag == a) do_snoop(a);
                if (op == 6) begin
                    do_abort(a, a ^ 32'h10, 1'b0, w, g, $urandom_range(0, w + g + 1));
                    do_load(a ^ 32'h10, w, g, $urandom, -1);
                end else begin
                    do_abort(a, a, 1'b1, w, g, $urandom_range(0, w + g + 1));
                    do_load(a, w, g, $urandom, -1);
                end
            end else if (op == 8) begin
                do_snoop(a);
            end else begin
                do_reset_mid(32'hA000_0000 + 32'(n * 16), w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
